// File: rtl/axi_uart_tx.sv
// AXI-lite style console UART transmitter: TXDATA writes feed a FIFO drained by an 8N1 shifter.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit enabled by BAUD[16].
module axi_uart_tx #(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 434,
  parameter int ID_W        = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_axi_awvalid,
  input  logic [31:0]     i_axi_awaddr,
  input  logic [ID_W-1:0] i_axi_awid,
  input  logic            i_axi_wvalid,
  input  logic [31:0]     i_axi_wdata,
  input  logic            i_axi_bready,
  input  logic            i_axi_arvalid,
  input  logic [31:0]     i_axi_araddr,
  input  logic [ID_W-1:0] i_axi_arid,
  input  logic            i_axi_rready,
  output logic            o_axi_awready,
  output logic            o_axi_wready,
  output logic            o_axi_bvalid,
  output logic [ID_W-1:0] o_axi_bid,
  output logic [1:0]      o_axi_bresp,
  output logic            o_axi_arready,
  output logic            o_axi_rvalid,
  output logic [ID_W-1:0] o_axi_rid,
  output logic [31:0]     o_axi_rdata,
  output logic [1:0]      o_axi_rresp,
  output logic            o_axi_rlast,
  output logic            tx_o,
  output logic            irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(FIFO_DEPTH);
  localparam logic [15:0]   DIV_RST  = 16'(DEFAULT_DIV);

  typedef enum logic [1:0] {T_TXDATA, T_BAUD, T_NONE} wsel_t;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr, w_count;
  logic            w_empty, w_full, w_push, w_load, w_shift, w_last, w_busy;
  logic            r_pend_wr, r_bvalid, r_rvalid;
  wsel_t           r_wsel, w_aw_sel;
  logic [ID_W-1:0] r_awid, r_bid, r_rid;
  logic [31:0]     r_rdata, w_rd_val;
  logic [15:0]     r_div_cfg, r_div, r_tick;
  logic            w_wready, w_whs, w_baud_wr;
  state_t          r_state, w_state_next;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shift;
  logic            r_tx, w_tx_next, r_irq;
  logic            w_par_cfg, w_par_on, w_par_bit;
  logic            w_unused;

  assign w_count   = r_wr_ptr - r_rd_ptr;
  assign w_empty   = (w_count == '0);
  assign w_full    = (w_count == FULL_CNT);
  assign w_busy    = (r_state != S_IDLE);
  assign w_wready  = r_pend_wr && !(r_wsel == T_TXDATA && w_full);
  assign w_whs     = i_axi_wvalid && w_wready;
  assign w_push    = w_whs && (r_wsel == T_TXDATA);
  assign w_baud_wr = w_whs && (r_wsel == T_BAUD);
  assign w_last    = (r_tick == r_div - 16'd1);
  assign w_shift   = (r_state == S_DATA) && w_last;

  assign o_axi_awready = 1'b1;
  assign o_axi_arready = 1'b1;
  assign o_axi_wready  = w_wready;
  assign o_axi_bvalid  = r_bvalid;
  assign o_axi_bid     = r_bid;
  assign o_axi_bresp   = 2'b00;
  assign o_axi_rvalid  = r_rvalid;
  assign o_axi_rid     = r_rid;
  assign o_axi_rdata   = r_rdata;
  assign o_axi_rresp   = 2'b00;
  assign o_axi_rlast   = r_rvalid;
  assign tx_o          = r_tx;
  assign irq_o         = r_irq;

`ifdef UART_TX_PARITY_EN
  logic r_par_en, r_par_on, r_par;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par_en <= 1'b1;
      r_par_on <= 1'b0;
    end else begin
      if (w_baud_wr) r_par_en <= i_axi_wdata[16];
      if (w_load)    r_par_on <= r_par_en;
    end
  end
  always_ff @(posedge clk) begin
    if (w_load) r_par <= ^r_mem[r_rd_ptr[AW-1:0]];
  end
  assign w_par_cfg = r_par_en;
  assign w_par_on  = r_par_on;
  assign w_par_bit = r_par;
  assign w_unused  = ^{i_axi_awaddr[31:16], i_axi_araddr[31:16], i_axi_wdata[31:17]};
`else
  assign w_par_cfg = 1'b0;
  assign w_par_on  = 1'b0;
  assign w_par_bit = 1'b0;
  assign w_unused  = ^{i_axi_awaddr[31:16], i_axi_araddr[31:16], i_axi_wdata[31:16]};
`endif

  always_comb begin
    w_aw_sel = T_NONE;
    case (i_axi_awaddr[15:0])
      16'h0000: w_aw_sel = T_TXDATA;
      16'h0008: w_aw_sel = T_BAUD;
      default:  w_aw_sel = T_NONE;
    endcase
  end

  always_comb begin
    w_rd_val = '0;
    case (i_axi_araddr[15:0])
      16'h0004: w_rd_val = {16'h0, 8'(w_count), 5'b0, w_full, w_empty, w_busy};
      16'h0008: w_rd_val = {15'h0, w_par_cfg, r_div_cfg};
      default:  w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_wr <= 1'b0;
      r_wsel    <= T_NONE;
      r_awid    <= '0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_div_cfg <= DIV_RST;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
    end else begin
      if (i_axi_awvalid && !r_pend_wr && !r_bvalid) begin
        r_pend_wr <= 1'b1;
        r_wsel    <= w_aw_sel;
        r_awid    <= i_axi_awid;
      end
      if (w_whs) begin
        r_pend_wr <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bid     <= r_awid;
      end else if (r_bvalid && i_axi_bready) begin
        r_bvalid <= 1'b0;
      end
      if (w_baud_wr)
        r_div_cfg <= (i_axi_wdata[15:0] < 16'd2) ? 16'd2 : i_axi_wdata[15:0];
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
      // Read data is captured with the address so it stays stable while rready is low.
      if (i_axi_arvalid && !r_rvalid) begin
        r_rvalid <= 1'b1;
        r_rid    <= i_axi_arid;
        r_rdata  <= w_rd_val;
      end else if (r_rvalid && i_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_axi_wdata[7:0];
    if (w_load)       r_shift <= r_mem[r_rd_ptr[AW-1:0]];
    else if (w_shift) r_shift <= {1'b0, r_shift[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      S_IDLE: if (!w_empty) begin
        w_load       = 1'b1;
        w_state_next = S_START;
      end
      S_START:  if (w_last) w_state_next = S_DATA;
      S_DATA:   if (w_last && r_bitcnt == 3'd7) w_state_next = w_par_on ? S_PARITY : S_STOP;
      S_PARITY: if (w_last) w_state_next = S_STOP;
      S_STOP: if (w_last) begin
        if (!w_empty) begin
          w_load       = 1'b1;
          w_state_next = S_START;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    // tx is registered from the next state so the pin never glitches.
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift ? r_shift[1] : r_shift[0];
      S_PARITY: w_tx_next = w_par_bit;
      default:  w_tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick   <= '0;
      r_bitcnt <= '0;
      r_div    <= DIV_RST;
      r_tx     <= 1'b1;
      r_irq    <= 1'b1;
    end else begin
      r_tx  <= w_tx_next;
      r_irq <= w_empty && !w_busy;
      if (r_state == S_IDLE || w_last) r_tick <= '0;
      else                             r_tick <= r_tick + 16'd1;
      if (w_load) begin
        r_div    <= r_div_cfg;
        r_bitcnt <= '0;
      end else if (w_shift) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end
    end
  end
endmodule
